// File: rtl/larpix_packet_pkg.sv
// Shared packet definitions for the config responder: field positions,
// packet declare codes, FSM states and the reply builder with odd parity.
package larpix_packet_pkg;

   localparam int PKT_W             = 64;
   localparam int PAYLOAD_W         = PKT_W - 1;
   localparam int GLOBAL_ID_DEFAULT = 255;

   localparam int DECL_LSB = 0;
   localparam int ID_LSB   = 2;
   localparam int ADDR_LSB = 10;
   localparam int DATA_LSB = 18;
   localparam int DOWN_BIT = 62;

   typedef enum logic [1:0] {
      DECL_DATA   = 2'd0,
      DECL_TEST   = 2'd1,
      DECL_CFG_WR = 2'd2,
      DECL_CFG_RD = 2'd3
   } declare_e;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_UNLOAD  = 3'd1,
      ST_CAPTURE = 3'd2,
      ST_DECODE  = 3'd3,
      ST_WAIT_TX = 3'd4,
      ST_LOAD    = 3'd5
   } state_e;

   // Parity bit that makes the total count of ones in the packet odd.
   function automatic logic odd_parity(input logic [PAYLOAD_W-1:0] payload);
      return ~(^payload);
   endfunction

   function automatic logic [PKT_W-1:0] build_reply(input declare_e   decl,
                                                    input logic [7:0] id,
                                                    input logic [7:0] addr,
                                                    input logic [7:0] data);
      logic [PAYLOAD_W-1:0] payload;
      payload                 = '0;
      payload[DECL_LSB +: 2]  = decl;
      payload[ID_LSB +: 8]    = id;
      payload[ADDR_LSB +: 8]  = addr;
      payload[DATA_LSB +: 8]  = data;
      payload[DOWN_BIT]       = 1'b1;
      return {odd_parity(payload), payload};
   endfunction

endpackage

// File: rtl/config_regmap.sv
// Byte-wide register map: one write port, two independent combinational
// read ports. Out-of-range writes are ignored, out-of-range reads return 0.
module config_regmap
   import larpix_packet_pkg::*;
#(
   parameter int REGNUM = 256
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       we,
   input  logic [7:0] waddr,
   input  logic [7:0] wdata,
   input  logic [7:0] raddr_a,
   output logic [7:0] rdata_a,
   input  logic [7:0] raddr_b,
   output logic [7:0] rdata_b
);

   localparam logic [8:0] DEPTH = 9'(REGNUM);

   logic [7:0] mem_q [REGNUM];

   function automatic logic in_range(input logic [7:0] addr);
      return {1'b0, addr} < DEPTH;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < REGNUM; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we && in_range(waddr)) begin
         mem_q[waddr] <= wdata;
      end
   end

   always_comb begin
      rdata_a = '0;
      rdata_b = '0;
      if (in_range(raddr_a)) rdata_a = mem_q[raddr_a];
      if (in_range(raddr_b)) rdata_b = mem_q[raddr_b];
   end

endmodule

// File: rtl/config_packet_responder.sv
// Pulls packets from uart_rx, services config reads/writes addressed to this
// chip (or broadcast) and hands the reply to uart_tx.
module config_packet_responder
   import larpix_packet_pkg::*;
#(
   parameter int WIDTH     = PKT_W,
   parameter int REGNUM    = 256,
   parameter int GLOBAL_ID = GLOBAL_ID_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       chip_id,
   input  logic [WIDTH-2:0] rx_data,
   input  logic             rx_empty,
   input  logic             parity_error,
   output logic             uld_rx_data,
   output logic [WIDTH-1:0] tx_data,
   output logic             ld_tx_data,
   input  logic             tx_busy,
   input  logic [7:0]       cfg_addr,
   output logic [7:0]       cfg_data,
   output logic [7:0]       parity_err_cnt,
   output logic [2:0]       dbg_state,
   output logic [WIDTH-2:0] dbg_capture
);

   localparam logic [7:0] GLOBAL_ID_B = 8'(GLOBAL_ID);

   state_e           state_q, state_d;
   logic [WIDTH-2:0] rx_q, rx_d;
   logic             perr_q, perr_d;
   logic [WIDTH-1:0] tx_q, tx_d;
   logic [7:0]       cnt_q, cnt_d;

   logic             reg_we;
   logic [7:0]       reg_rdata;

   declare_e         pkt_decl;
   logic [7:0]       pkt_id;
   logic [7:0]       pkt_addr;
   logic [7:0]       pkt_data;
   logic             id_match;
   logic             is_cfg;

   assign pkt_decl = declare_e'(rx_q[DECL_LSB +: 2]);
   assign pkt_id   = rx_q[ID_LSB +: 8];
   assign pkt_addr = rx_q[ADDR_LSB +: 8];
   assign pkt_data = rx_q[DATA_LSB +: 8];
   assign id_match = (pkt_id == chip_id) || (pkt_id == GLOBAL_ID_B);
   assign is_cfg   = (pkt_decl == DECL_CFG_WR) || (pkt_decl == DECL_CFG_RD);

   config_regmap #(
      .REGNUM (REGNUM)
   ) u_regmap (
      .clk     (clk),
      .reset   (reset),
      .we      (reg_we),
      .waddr   (pkt_addr),
      .wdata   (pkt_data),
      .raddr_a (pkt_addr),
      .rdata_a (reg_rdata),
      .raddr_b (cfg_addr),
      .rdata_b (cfg_data)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         rx_q    <= '0;
         perr_q  <= 1'b0;
         tx_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         rx_q    <= rx_d;
         perr_q  <= perr_d;
         tx_q    <= tx_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      rx_d        = rx_q;
      perr_d      = perr_q;
      tx_d        = tx_q;
      cnt_d       = cnt_q;
      uld_rx_data = 1'b0;
      ld_tx_data  = 1'b0;
      reg_we      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!rx_empty) state_d = ST_UNLOAD;
         end
         ST_UNLOAD: begin
            uld_rx_data = 1'b1;
            state_d     = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            rx_d    = rx_data;
            perr_d  = parity_error;
            state_d = ST_DECODE;
         end
         ST_DECODE: begin
            state_d = ST_IDLE;
            if (perr_q) begin
               if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
            end else if (is_cfg && id_match) begin
               // Read data comes from the map before this cycle's write lands.
               reg_we  = (pkt_decl == DECL_CFG_WR);
               tx_d    = build_reply(pkt_decl, chip_id, pkt_addr,
                                     (pkt_decl == DECL_CFG_WR) ? pkt_data : reg_rdata);
               state_d = ST_WAIT_TX;
            end
         end
         ST_WAIT_TX: begin
            if (!tx_busy) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            ld_tx_data = 1'b1;
            state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign tx_data        = tx_q;
   assign parity_err_cnt = cnt_q;
   assign dbg_state      = state_q;
   assign dbg_capture    = rx_q;

endmodule

// File: tb/tb_config_packet_responder.sv
// Randomized bench for config_packet_responder against a register-array and
// reply-queue reference model.
module tb_config_packet_responder;
   import larpix_packet_pkg::*;

   localparam logic [7:0] CHIP = 8'h10;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [62:0] rx_data = '0;
   logic        rx_empty = 1'b1;
   logic        parity_error = 1'b0;
   logic        uld_rx_data;
   logic [63:0] tx_data;
   logic        ld_tx_data;
   logic        tx_busy = 1'b0;
   logic [7:0]  cfg_addr = '0;
   logic [7:0]  cfg_data;
   logic [7:0]  parity_err_cnt;
   logic [2:0]  dbg_state;
   logic [62:0] dbg_capture;

   config_packet_responder dut (
      .clk            (clk),
      .reset          (reset),
      .chip_id        (CHIP),
      .rx_data        (rx_data),
      .rx_empty       (rx_empty),
      .parity_error   (parity_error),
      .uld_rx_data    (uld_rx_data),
      .tx_data        (tx_data),
      .ld_tx_data     (ld_tx_data),
      .tx_busy        (tx_busy),
      .cfg_addr       (cfg_addr),
      .cfg_data       (cfg_data),
      .parity_err_cnt (parity_err_cnt),
      .dbg_state      (dbg_state),
      .dbg_capture    (dbg_capture)
   );

   always #5 clk = ~clk;

   int          cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [63:0] exp_q[$];
   logic [7:0]  model [256];
   int          model_perr = 0;
   int          drive_cyc, uld_cyc, ld_cyc;
   logic [63:0] last_exp;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] reply(input logic [1:0] d, input logic [7:0] a,
                                          input logic [7:0] v);
      logic [63:0] p;
      p = (64'd1 << 62) | (64'(v) << 18) | (64'(a) << 10) | (64'(CHIP) << 2) | 64'(d);
      if ($countones(p) % 2 == 0) p = p | (64'd1 << 63);
      return p;
   endfunction

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_pkt(input logic [1:0] decl, input logic [7:0] id,
                           input logic [7:0] addr, input logic [7:0] data,
                           input logic perr);
      logic [62:0] p;
      bit          seen;
      seen = 0;
      @(negedge clk);
      p          = '0;
      p[61:26]   = 36'({$urandom(), $urandom()});
      p[25:18]   = data;
      p[17:10]   = addr;
      p[9:2]     = id;
      p[1:0]     = decl;
      rx_data      = p;
      parity_error = perr;
      rx_empty     = 1'b0;
      drive_cyc    = cyc;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (uld_rx_data) begin
            seen = 1;
            break;
         end
      end
      check("uld_seen", 64'(seen), 64'd1);
      if (!seen) return;
      uld_cyc = cyc;
      @(negedge clk);
      rx_empty = 1'b1;
      if (perr) begin
         if (model_perr < 255) model_perr++;
      end else if (decl >= 2'd2 && (id == CHIP || id == 8'hFF)) begin
         if (decl == 2'd2) begin
            last_exp    = reply(2'd2, addr, data);
            model[addr] = data;
         end else begin
            last_exp = reply(2'd3, addr, model[addr]);
         end
         exp_q.push_back(last_exp);
      end
   endtask

   task automatic check_cfg(input string tag, input logic [7:0] a);
      cfg_addr = a;
      #1;
      check(tag, 64'(cfg_data), 64'(model[a]));
   endtask

   // Every load strobe must carry the oldest outstanding expected reply.
   always @(negedge clk) begin
      if (!reset && ld_tx_data) begin
         ld_cyc = cyc;
         if (exp_q.size() == 0) check("unexpected_ld", 64'd1, 64'd0);
         else check("reply", tx_data, exp_q.pop_front());
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) model[i] = '0;

      // Reset state
      #12;
      check("rst_uld", 64'(uld_rx_data), 64'd0);
      check("rst_ld", 64'(ld_tx_data), 64'd0);
      check("rst_tx_data", tx_data, 64'd0);
      check("rst_perr_cnt", 64'(parity_err_cnt), 64'd0);
      check("rst_state", 64'(dbg_state), 64'd0);
      cfg_addr = 8'd5;
      #1;
      check("rst_cfg", 64'(cfg_data), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      wait_cycles(2);

      // Directed write then read, with latency check
      send_pkt(2'd2, CHIP, 8'd5, 8'hA5, 1'b0);
      wait_cycles(8);
      check("latency", 64'(ld_cyc - drive_cyc), 64'd5);
      check_cfg("cfg_after_wr", 8'd5);
      check("cfg_a5_literal", 64'(cfg_data), 64'hA5);
      send_pkt(2'd3, CHIP, 8'd5, 8'h00, 1'b0);
      wait_cycles(8);
      check_cfg("cfg_after_rd", 8'd5);

      // Chip-ID mismatch is dropped; broadcast is accepted
      send_pkt(2'd2, 8'h1F, 8'd7, 8'h3C, 1'b0);
      wait_cycles(8);
      check_cfg("cfg_mismatch", 8'd7);
      send_pkt(2'd2, 8'hFF, 8'd7, 8'h3C, 1'b0);
      wait_cycles(8);
      check_cfg("cfg_broadcast", 8'd7);

      // Back-to-back: pending packet accepted right after the load cycle
      send_pkt(2'd2, CHIP, 8'd20, 8'h5A, 1'b0);
      send_pkt(2'd3, CHIP, 8'd20, 8'h00, 1'b0);
      check("b2b_gap", 64'(uld_cyc - ld_cyc), 64'd2);
      wait_cycles(8);

      // Randomized traffic, packets issued back to back
      for (int n = 0; n < 200; n++) begin
         logic [7:0] id;
         case ($urandom_range(0, 2))
            0:       id = CHIP;
            1:       id = 8'hFF;
            default: id = 8'($urandom_range(0, 255));
         endcase
         send_pkt(2'($urandom_range(0, 3)), id, 8'($urandom_range(0, 15)),
                  8'($urandom_range(0, 255)), ($urandom_range(0, 9) == 0));
      end
      wait_cycles(10);
      check("rand_perr_cnt", 64'(parity_err_cnt), 64'(model_perr));
      for (int a = 0; a < 256; a++) check_cfg("rand_cfg_sweep", 8'(a));

      // Transmitter busy: reply must hold, then load one cycle after release
      tx_busy = 1'b1;
      send_pkt(2'd3, CHIP, 8'd5, 8'h00, 1'b0);
      wait_cycles(2);
      for (int i = 0; i < 100; i++) begin
         check("busy_ld_low", 64'(ld_tx_data), 64'd0);
         check("busy_tx_hold", tx_data, last_exp);
         @(negedge clk);
      end
      tx_busy = 1'b0;
      @(negedge clk);
      check("busy_ld_pulse", 64'(ld_tx_data), 64'd1);
      @(negedge clk);
      check("busy_ld_single", 64'(ld_tx_data), 64'd0);
      wait_cycles(4);

      // Parity errors: counted with saturation, nothing else changes
      for (int n = 0; n < 300; n++) send_pkt(2'd2, CHIP, 8'd7, 8'h99, 1'b1);
      wait_cycles(8);
      check("perr_cnt_sat", 64'(parity_err_cnt), 64'(model_perr));
      check("perr_cnt_255", 64'(parity_err_cnt), 64'd255);
      check_cfg("perr_cfg7", 8'd7);
      check_cfg("perr_cfg5", 8'd5);

      // Reset while a reply waits for the transmitter
      tx_busy = 1'b1;
      send_pkt(2'd2, CHIP, 8'd9, 8'h77, 1'b0);
      wait_cycles(2);
      check("pre_rst_tx", tx_data, last_exp);
      reset = 1'b1;
      #1;
      exp_q.delete();
      for (int i = 0; i < 256; i++) model[i] = '0;
      model_perr = 0;
      check("mid_rst_uld", 64'(uld_rx_data), 64'd0);
      check("mid_rst_ld", 64'(ld_tx_data), 64'd0);
      check("mid_rst_tx", tx_data, 64'd0);
      check("mid_rst_cnt", 64'(parity_err_cnt), 64'd0);
      check_cfg("mid_rst_cfg9", 8'd9);
      wait_cycles(2);
      reset   = 1'b0;
      tx_busy = 1'b0;
      wait_cycles(20);
      check_cfg("post_rst_cfg9", 8'd9);
      check("post_rst_state", 64'(dbg_state), 64'd0);

      check("replies_drained", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
